// File: rtl/lms_iq_deinterleaver.sv
// lms_iq_deinterleaver: recovers parallel I/Q pairs from the LMS
// 12-bit interleaved bus, with IQSEL lock tracking and slip counting.
module lms_iq_deinterleaver #(
  parameter int   WIDTH      = 12,
  parameter int   LOCK_COUNT = 8,
  parameter logic I_LEVEL    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iqsel,
  input  logic [WIDTH-1:0] data,
  input  logic             clear_err,
  output logic [WIDTH-1:0] i_out,
  output logic [WIDTH-1:0] q_out,
  output logic             strobe,
  output logic             locked,
  output logic [15:0]      err_count
);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_CHECK,
    ST_LOCK
  } state_t;

  localparam logic [7:0] LAST = 8'(LOCK_COUNT - 1);

  logic             s_sel;
  logic             p_sel;
  logic [WIDTH-1:0] s_dat;
  logic [WIDTH-1:0] i_hold;
  state_t           state;
  state_t           state_n;
  logic [7:0]       cnt;
  logic [7:0]       cnt_n;
  logic             alt;
  logic             err_inc;
  logic             pair_ok;

  assign alt     = s_sel ^ p_sel;
  assign pair_ok = (state == ST_LOCK) && alt
                   && (s_sel != I_LEVEL);

  // register the bus and keep the previous framing bit and last I word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_sel  <= 1'b0;
      p_sel  <= 1'b0;
      s_dat  <= '0;
      i_hold <= '0;
    end else begin
      s_sel <= iqsel;
      s_dat <= data;
      p_sel <= s_sel;
      if (s_sel == I_LEVEL)
        i_hold <= s_dat;
    end
  end

  // lock FSM next state: count alternations, drop on any repeat
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    err_inc = 1'b0;
    unique case (state)
      ST_HUNT: begin
        if (alt) begin
          state_n = ST_CHECK;
          cnt_n   = 8'd1;
        end
      end
      ST_CHECK: begin
        if (!alt) begin
          state_n = ST_HUNT;
          cnt_n   = 8'd0;
        end else if (cnt == LAST) begin
          state_n = ST_LOCK;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      ST_LOCK: begin
        if (!alt) begin
          state_n = ST_HUNT;
          cnt_n   = 8'd0;
          err_inc = 1'b1;
        end
      end
      default: begin
        state_n = ST_HUNT;
        cnt_n   = 8'd0;
      end
    endcase
  end

  // lock FSM state, good-alternation count and lock flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_HUNT;
      cnt    <= 8'd0;
      locked <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      locked <= (state_n == ST_LOCK);
    end
  end

  // emit a pair when a Q word follows an I word while locked
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_out  <= '0;
      q_out  <= '0;
      strobe <= 1'b0;
    end else begin
      strobe <= pair_ok;
      if (pair_ok) begin
        i_out <= i_hold;
        q_out <= s_dat;
      end
    end
  end

  // saturating slip counter, clear wins over a same-cycle slip
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= 16'd0;
    end else if (clear_err) begin
      err_count <= 16'd0;
    end else if (err_inc && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end

endmodule
